fdiv_pcpi_sequencer: RTL
========================

Name: fdiv_pcpi_sequencer

Overview:
Front-end/back-end stage for the fp32 divider. It decodes a custom FDIV.S instruction on the picorv32 PCPI bus and drives divider operands with the STB/BUSY input handshake. It then consumes the divider result through the STB/BUSY output handshake and returns it to the core as pcpi_rd. A watchdog returns a NaN and flags an error if the divider stalls; an aborted or late result is drained and discarded.

Parameters:
FUNCT7, 7'b0000101, insn[31:25] match value
FUNCT3, 3'b000, insn[14:12] match value (opcode fixed 7'b0001011, custom-0)
TIMEOUT_CYCLES, 255, maximum cycles spent in ISSUE+WAIT_RES before timeout (1..65535)
TIMEOUT_VAL, 32'hFFC00000, pcpi_rd value returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pcpi_valid  in  1  core presents instruction
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  dividend (fp32)
pcpi_rs2  in  32  divisor (fp32)
pcpi_wr  out  1  write pcpi_rd to rd; pulses with pcpi_ready
pcpi_rd  out  32  result
pcpi_wait  out  1  instruction claimed, stall core
pcpi_ready  out  1  one-cycle completion pulse
input_a  out  32  divider operand a
input_b  out  32  divider operand b
div_input_STB  out  1  operands valid
div_BUSY  in  1  divider cannot accept
output_div  in  32  divider result
div_output_STB  in  1  result valid
output_module_BUSY  out  1  this block cannot accept a result
timeout_err  out  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- All outputs are registered. Reset values: pcpi_wr=0, pcpi_ready=0, pcpi_wait=0, pcpi_rd=0, input_a=0, input_b=0, div_input_STB=0, output_module_BUSY=1, timeout_err=0, state=IDLE, counter=0.
- match = pcpi_valid && insn[6:0]==7'b0001011 && insn[14:12]==FUNCT3 && insn[31:25]==FUNCT7.
- IDLE: on match, latch input_a=rs1 and input_b=rs2, set div_input_STB=1, pcpi_wait=1, counter=0, and go to ISSUE. A non-matching instruction produces no reaction.
- ISSUE: hold STB and operands. Acceptance occurs on the edge where STB=1 and div_BUSY=0.
  - On acceptance: STB→0, output_module_BUSY→0, go to WAIT_RES. If pcpi_valid=0 on that same edge, go to DRAIN instead.
  - If not accepted and pcpi_valid=0 (abort): STB→0, pcpi_wait→0, go to IDLE.
  - If not accepted and counter reaches TIMEOUT_CYCLES-1: STB→0, go to RESPOND with pcpi_rd=TIMEOUT_VAL, set timeout_err.
- WAIT_RES: output_module_BUSY=0. The result is consumed on the edge where div_output_STB=1 and output_module_BUSY=0.
  - On consumption: pcpi_rd=output_div, output_module_BUSY→1, go to RESPOND.
  - If pcpi_valid=0 before consumption: go to DRAIN.
  - On timeout: pcpi_rd=TIMEOUT_VAL, set timeout_err, go to RESPOND and mark a drain as pending.
- RESPOND (1 cycle): pcpi_ready=1, pcpi_wr=1, pcpi_wait→0. Next state is DRAIN if a drain is pending, otherwise IDLE. Ready and wr are 0 in every other state.
- DRAIN: output_module_BUSY=0. On div_output_STB=1: discard the result, set output_module_BUSY=1, go to IDLE. A match during DRAIN sets pcpi_wait=1 but is not issued until IDLE; the IDLE match check then re-evaluates it.
- counter: 16 bits, increments each cycle in ISSUE/WAIT_RES, saturates, and clears on entry to ISSUE. It never counts in DRAIN.
- The divider keeps BUSY=1 for one cycle after its result is consumed, so a back-to-back issue waits in ISSUE; this is legal.
- Latency: match at cycle T → STB at T+1 → pcpi_ready one cycle after result consumption.
- rst at any point forces reset values and IDLE, with no drain pending. rst is shared with the divider, so no stale result survives.
- Operands are passed through unmodified; all special-case handling is the divider's responsibility.

Test Plan:
- FDIV rs1=0x40C00000 (6.0), rs2=0x40000000 (2.0) → single STB accept; pcpi_rd=0x40400000, pcpi_wr=pcpi_ready=1 for exactly 1 cycle; timeout_err=0.
- rs1=0x3F800000, rs2=0x00000000 → pcpi_rd=0x7F800000. Also rs1=0x00000000, rs2=0x00000000 → pcpi_rd=0xFFC00000.
- Non-matching insn (funct7=0000001) with pcpi_valid held 20 cycles → pcpi_wait, div_input_STB and pcpi_ready all stay 0.
- Stub divider holding div_BUSY=1, TIMEOUT_CYCLES=16 → pcpi_ready exactly 16 cycles after STB rises, pcpi_rd=0xFFC00000, timeout_err=1 sticky until rst.
- Abort: drop pcpi_valid 10 cycles after acceptance → no pcpi_ready. Result later consumed in DRAIN (output_module_BUSY=0 then 1). A following FDIV 0x41200000/0x40A00000 returns 0x40000000.
- Assert rst in WAIT_RES → next cycle all outputs at reset values, state IDLE. A fresh FDIV then completes correctly.

Source files
------------

// File: rtl/fdiv_pcpi_sequencer.sv
// PCPI front-end for the fp32 divider: decodes FDIV.S, issues operands over STB/BUSY,
// returns the divider result as pcpi_rd, and times out to a NaN if the divider stalls.
module fdiv_pcpi_sequencer #(
  parameter logic [6:0]  FUNCT7         = 7'b0000101,
  parameter logic [2:0]  FUNCT3         = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_VAL    = 32'hFFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [31:0] input_a,
  output logic [31:0] input_b,
  output logic        div_input_STB,
  input  logic        div_BUSY,
  input  logic [31:0] output_div,
  input  logic        div_output_STB,
  output logic        output_module_BUSY,
  output logic        timeout_err
);
  localparam logic [6:0]  OPCODE   = 7'b0001011;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, RESPOND, DRAIN} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic        drain_pend, drain_pend_n;
  logic        wr_n, ready_n, wait_n, stb_n, obusy_n, terr_n;
  logic [31:0] rd_n, a_n, b_n;
  logic        match, accept, consume, expired;

  assign match   = pcpi_valid && (pcpi_insn[6:0] == OPCODE) &&
                   (pcpi_insn[14:12] == FUNCT3) && (pcpi_insn[31:25] == FUNCT7);
  assign accept  = div_input_STB && !div_BUSY;
  assign consume = div_output_STB && !output_module_BUSY;
  assign expired = (cnt == CNT_LAST);
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      drain_pend         <= 1'b0;
      pcpi_wr            <= 1'b0;
      pcpi_ready         <= 1'b0;
      pcpi_wait          <= 1'b0;
      pcpi_rd            <= '0;
      input_a            <= '0;
      input_b            <= '0;
      div_input_STB      <= 1'b0;
      output_module_BUSY <= 1'b1;
      timeout_err        <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      drain_pend         <= drain_pend_n;
      pcpi_wr            <= wr_n;
      pcpi_ready         <= ready_n;
      pcpi_wait          <= wait_n;
      pcpi_rd            <= rd_n;
      input_a            <= a_n;
      input_b            <= b_n;
      div_input_STB      <= stb_n;
      output_module_BUSY <= obusy_n;
      timeout_err        <= terr_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    drain_pend_n = drain_pend;
    wr_n         = 1'b0;
    ready_n      = 1'b0;
    wait_n       = pcpi_wait;
    rd_n         = pcpi_rd;
    a_n          = input_a;
    b_n          = input_b;
    stb_n        = div_input_STB;
    obusy_n      = output_module_BUSY;
    terr_n       = timeout_err;
    case (state)
      IDLE: begin
        wait_n = match;
        if (match) begin
          a_n     = pcpi_rs1;
          b_n     = pcpi_rs2;
          stb_n   = 1'b1;
          cnt_n   = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n = cnt_inc;
        if (accept) begin
          stb_n   = 1'b0;
          obusy_n = 1'b0;
          if (pcpi_valid) state_n = WAIT_RES;
          else begin
            // Divider already owns the operands, so its result must still be swallowed.
            wait_n  = 1'b0;
            state_n = DRAIN;
          end
        end else if (!pcpi_valid) begin
          stb_n   = 1'b0;
          wait_n  = 1'b0;
          state_n = IDLE;
        end else if (expired) begin
          stb_n   = 1'b0;
          rd_n    = TIMEOUT_VAL;
          terr_n  = 1'b1;
          ready_n = 1'b1;
          wr_n    = 1'b1;
          wait_n  = 1'b0;
          state_n = RESPOND;
        end
      end
      WAIT_RES: begin
        cnt_n = cnt_inc;
        if (consume) begin
          rd_n    = output_div;
          obusy_n = 1'b1;
          ready_n = 1'b1;
          wr_n    = 1'b1;
          wait_n  = 1'b0;
          state_n = RESPOND;
        end else if (!pcpi_valid) begin
          wait_n  = 1'b0;
          state_n = DRAIN;
        end else if (expired) begin
          // Block the late result during RESPOND; DRAIN reopens the handshake.
          rd_n         = TIMEOUT_VAL;
          terr_n       = 1'b1;
          obusy_n      = 1'b1;
          ready_n      = 1'b1;
          wr_n         = 1'b1;
          wait_n       = 1'b0;
          drain_pend_n = 1'b1;
          state_n      = RESPOND;
        end
      end
      RESPOND: begin
        if (drain_pend) begin
          drain_pend_n = 1'b0;
          obusy_n      = 1'b0;
          state_n      = DRAIN;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        wait_n = match;
        if (consume) begin
          obusy_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
